// File: rtl/cpc_romsel_pkg.sv
// Shared types and constants for the CPC upper-ROM select front end.
package cpc_romsel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HOLD = 2'd2
    } wr_state_t;

    localparam logic ROMSEL_PORT_A13 = 1'b0;
    localparam int   NUM_SLOTS       = 8;
    localparam int   SLOT_W          = 3;
    localparam int   CNT_W           = 3;

    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
        return NUM_SLOTS'(1) << slot;
    endfunction

endpackage

// File: rtl/cpc_romsel_capture_if.sv
// Z80 edge-connector signals seen by the ROM-select front end.
interface cpc_romsel_capture_if;

    logic       iorq_b;
    logic       wr_b;
    logic       a13;
    logic       a14;
    logic       romen_b;
    logic [7:0] d;

    modport master (output iorq_b, wr_b, a13, a14, romen_b, d);
    modport slave  (input  iorq_b, wr_b, a13, a14, romen_b, d);

endinterface

// File: rtl/cpc_bus_sync.sv
// N-bit multi-flop synchroniser with a per-bit reset value.
module cpc_bus_sync #(
    parameter int               WIDTH       = 1,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= RST_VAL;
            end
        end else begin
            sync_p[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign dout = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/cpc_romsel_capture.sv
// Oversampled ROM-select port capture and slot decode for the CPC upper-ROM board.
// Optional macro ROMSEL_BANK_EN: the bank jumper selects which half (0..7 / 8..15) of rom_num hits.
module cpc_romsel_capture
    import cpc_romsel_pkg::*;
#(
    parameter int         WR_MIN      = 3,
    parameter logic [7:0] RESET_ROM   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    cpc_romsel_capture_if.slave    bus,
    input  logic [NUM_SLOTS-1:0]   slot_en,
    input  logic                   bank,
    output logic [7:0]             rom_num,
    output logic [NUM_SLOTS-1:0]   cs_b,
    output logic [NUM_SLOTS/2-1:0] romcs_pair_b,
    output logic                   rom_a14,
    output logic                   romdis,
    output logic                   sel_valid
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [NUM_SLOTS/2-1:0] pair_and(input logic [NUM_SLOTS-1:0] c);
        logic [NUM_SLOTS/2-1:0] p;
        for (int i = 0; i < NUM_SLOTS/2; i++) begin
            p[i] = c[2*i] & c[2*i+1];
        end
        return p;
    endfunction

    logic [5:0] ctl_s;
    logic [7:0] d_s;
    logic       iorq_b_s, wr_b_s, a13_s, a14_s, romen_b_s, bank_s;
    logic       wstb;
    logic       bank_eff;

    // Strobes sync to their inactive level; a14 and bank clear to 0.
    cpc_bus_sync #(
        .WIDTH       (6),
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (6'b111010)
    ) u_ctl_sync (
        .clk   (clk),
        .reset (reset),
        .din   ({bus.iorq_b, bus.wr_b, bus.a13, bus.a14, bus.romen_b, bank}),
        .dout  (ctl_s)
    );

    cpc_bus_sync #(
        .WIDTH       (8),
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (8'h00)
    ) u_data_sync (
        .clk   (clk),
        .reset (reset),
        .din   (bus.d),
        .dout  (d_s)
    );

    assign {iorq_b_s, wr_b_s, a13_s, a14_s, romen_b_s, bank_s} = ctl_s;
    assign wstb = !iorq_b_s && !wr_b_s && (a13_s == ROMSEL_PORT_A13);

`ifdef ROMSEL_BANK_EN
    assign bank_eff = bank_s;
`else
    logic unused_bank_s;
    assign unused_bank_s = bank_s;
    assign bank_eff      = 1'b0;
`endif

    wr_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = sat_inc(cnt);

    // Capture FSM: a write must persist WR_MIN cycles, then exactly one capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rom_num <= RESET_ROM;
        end else begin
            case (state)
                IDLE: begin
                    if (wstb) begin
                        cnt <= CNT_W'(1);
                        if (WR_MIN <= 1) begin
                            rom_num <= d_s;
                            state   <= HOLD;
                        end else begin
                            state   <= QUAL;
                        end
                    end
                end
                QUAL: begin
                    if (!wstb) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_W'(WR_MIN)) begin
                            rom_num <= d_s;
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (wstb) begin
                        cnt <= cnt_inc;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [SLOT_W-1:0]    slot;
    logic                 sel_hit;
    logic                 hit;
    logic [NUM_SLOTS-1:0] cs_next;

    always_comb begin
        slot    = rom_num[SLOT_W-1:0];
        sel_hit = (rom_num[7:4] == 4'h0) && (rom_num[3] == bank_eff) && slot_en[slot];
        hit     = sel_hit && !romen_b_s && a14_s;
        cs_next = hit ? ~slot_onehot(slot) : '1;
    end

    // Decode stage: romdis shares the cs_b register stage so it never lags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_b         <= '1;
            romcs_pair_b <= '1;
            romdis       <= 1'b0;
            sel_valid    <= 1'b0;
        end else begin
            cs_b         <= cs_next;
            romcs_pair_b <= pair_and(cs_next);
            romdis       <= ~&cs_next;
            sel_valid    <= sel_hit;
        end
    end

    assign rom_a14 = rom_num[0];

endmodule

// File: doc/cpc_romsel_capture.md
Name: cpc_romsel_capture

Overview:
- Synchronous front end for the eight-slot CPC upper-ROM board. It replaces the transparent latch and its gating with logic clocked by a board oscillator.
- Oversamples the Z80 bus, qualifies I/O writes to the ROM-select port (A13 low), captures the ROM number, and decodes it to per-slot chip selects, pair selects, ROM A14 and ROMDIS.
- Sits between the edge connector and the EPROM/EEPROM sockets.

Parameters:
- WR_MIN, 3: consecutive synchronised cycles a qualified write must persist before capture.
- RESET_ROM, 8'h00: rom_num value after reset.
- SYNC_STAGES, 2: synchroniser depth for all bus inputs (legal values 2..3).

Ports:
- clk  in  1  board oscillator, at least 16 MHz; all logic rises on this edge
- reset  in  1  synchronous, active-high
- iorq_b  in  1  Z80 IOREQ_B
- wr_b  in  1  Z80 WR_B
- a13  in  1  address bit 13; low selects the ROM-select port
- a14  in  1  address bit 14; high for the upper-ROM window
- romen_b  in  1  CPC ROMEN_B
- d  in  8  Z80 data bus
- slot_en  in  8  DIP mask; bit n=1 populates slot n
- bank  in  1  bank jumper; used only with the macro defined
- rom_num  out  8  captured ROM-select value
- cs_b  out  8  per-slot chip selects, active low
- romcs_pair_b  out  4  AND of cs_b pairs (01, 23, 45, 67), active low
- rom_a14  out  1  rom_num[0]; picks the odd/even half of a 32K device
- romdis  out  1  high while any cs_b is low
- sel_valid  out  1  rom_num maps to a populated slot

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Every input passes through SYNC_STAGES flops. wstb = !iorq_b_s & !wr_b_s & !a13_s.
- Write-capture FSM:
  - IDLE: wstb=1 loads the counter with 1 and goes to QUAL.
  - QUAL: wstb=1 increments the counter. When the counter reaches WR_MIN, rom_num <= d_s on that cycle and the FSM goes to HOLD. wstb=0 before then returns to IDLE with no capture (glitch rejected).
  - HOLD: stays until wstb=0 for one cycle, then goes to IDLE. Exactly one capture per write however long the strobe lasts.
  - Counter is 3 bits and saturates; it never wraps.
- Capture latency: WR_MIN + SYNC_STAGES cycles from strobe assertion at the pins to rom_num updating.
- Decode:
  - hit = !romen_b_s & a14_s & (rom_num[7:4]==0) & (rom_num[3]==bank_eff) & slot_en[rom_num[2:0]].
  - bank_eff = 0 without the macro.
  - cs_b[n] = !(hit & rom_num[2:0]==n).
  - All decode outputs are registered: one cycle after the synchronised inputs change.
  - sel_valid = hit without the romen_b/a14 terms, registered.
- romdis = !&cs_b, registered in the same stage as cs_b, so it never lags the chip selects.
- rom_a14 = rom_num[0], combinational from the register.
- Reset values:
  - rom_num = RESET_ROM; FSM = IDLE; counter = 0; synchroniser flops cleared to the inactive level (strobes 1, d 0).
  - cs_b = 8'hFF, romcs_pair_b = 4'hF, romdis = 0, sel_valid = 0.
- Reset asserted mid-QUAL or mid-HOLD: FSM returns to IDLE and nothing is captured. A strobe still held when reset deasserts counts as a new write from cycle 1.
- romen_b toggling during a write: capture is unaffected; decode uses the old rom_num until the capture cycle, then the new one.
- slot_en changes take effect on the next decode cycle.

Optional Feature:
- ROMSEL_BANK_EN defined: bank_eff = synchronised bank, so rom_num 8..15 select slots 0..7 when bank=1.
- Undefined: bank is ignored and bank_eff = 0, so rom_num[3]=1 never hits.

Decomposition:
- Package cpc_romsel_pkg: FSM state enum {IDLE, QUAL, HOLD}, ROMSEL_PORT_A13 = 1'b0, NUM_SLOTS = 8, SLOT_W = 3.
- One natural sub-module, cpc_bus_sync: a parameterised N-bit, SYNC_STAGES-deep synchroniser with a per-bit reset value. Instantiate it twice, once for the strobes and once for the data bus.

Test Plan:
- Write 8'h05 with strobes low for 6 clk, then romen_b=0, a14=1, slot_en=8'hFF -> rom_num=05, cs_b=8'hDF, romcs_pair_b=4'hB, rom_a14=1, romdis=1.
- Write 8'h03 with the strobe low for 2 clk only -> no capture; rom_num keeps its prior value.
- Hold the strobe 40 clk while d changes from 8'h02 to 8'h07 at clk 20 -> single capture of 8'h02.
- rom_num=8'h12, or rom_num=8'h04 with slot_en=8'hEF -> cs_b=8'hFF, romdis=0, sel_valid=0.
- Assert reset at clk 2 of QUAL while writing 8'h06 -> rom_num=RESET_ROM and all outputs at reset values; reset drops with the strobe still low -> 8'h06 captured WR_MIN cycles later.
- With ROMSEL_BANK_EN, bank=1, write 8'h09 -> cs_b=8'hFD. Without the macro, same stimulus -> cs_b=8'hFF.
